// File: rtl/rf_refill_pkg.sv
// Shared definitions for the register-file refill writer.
//   refill_state_e : FSM encoding (IDLE, REQ, BEAT, DONE)
//   offs_w()       : word-offset width of a line (log2 of LINE_WORDS)
package rf_refill_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BEAT, DONE} refill_state_e;

  function automatic int offs_w(input int line_words);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < line_words) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/rf_refill_wr_stage.sv
// Registered register-file write-port driver.
// One accepted beat becomes one write strobe on the following cycle.
//   clk, rst        : clock, synchronous active-high reset (clears all flops)
//   i_we/i_addr/i_data : write request from the refill FSM
//   o_we/o_addr/o_data : registered write port towards the register file
module rf_refill_wr_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= i_we;
      // Address/data only move on a real write; they hold during gaps.
      if (i_we) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/rf_refill_writer.sv
// Write-side refill master for the register-file cache data store.
// Takes a line-refill command, issues one burst request to memory, writes
// LINE_WORDS response beats into the register file and pulses refill_done.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   refill_req_valid/ready/addr/line : refill command (accepted in IDLE)
//   mem_req_valid/ready/addr      : burst request towards next-level memory
//   mem_rsp_valid/ready/data      : response beats
//   WriteEnable/WriteAddr/WriteData : register-file write port (1-cycle latency)
//   refill_done                   : one-cycle pulse once the line is written
// Optional feature macro: RF_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   : request keeps the word offset, fill starts at the missing word
//   undefined : line-aligned request, fill starts at word 0
module rf_refill_writer
  import rf_refill_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_WORDS     = 4,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      refill_req_valid,
  output logic                                      refill_req_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]                 refill_req_addr,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]  refill_req_line,
  output logic                                      mem_req_valid,
  input  logic                                      mem_req_ready,
  output logic [MEM_ADDR_WIDTH-1:0]                 mem_req_addr,
  input  logic                                      mem_rsp_valid,
  output logic                                      mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]                     mem_rsp_data,
  output logic                                      WriteEnable,
  output logic [ADDR_WIDTH-1:0]                     WriteAddr,
  output logic [DATA_WIDTH-1:0]                     WriteData,
  output logic                                      refill_done
);

  localparam int OFFS_W   = offs_w(LINE_WORDS);
  localparam int WOFF_LSB = $clog2(DATA_WIDTH / 8);
  localparam int LINE_W   = ADDR_WIDTH - OFFS_W;
`ifdef RF_REFILL_CRITICAL_WORD_FIRST_EN
  localparam int CLR_BITS = WOFF_LSB;
`else
  localparam int CLR_BITS = OFFS_W + WOFF_LSB;
`endif
  localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((MEM_ADDR_WIDTH'(1) << CLR_BITS) - MEM_ADDR_WIDTH'(1));
  localparam logic [OFFS_W-1:0] LAST_BEAT = OFFS_W'(LINE_WORDS - 1);

  refill_state_e             r_state, w_next;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [LINE_W-1:0]         r_line;
  logic [OFFS_W-1:0]         r_offs;   // word being filled (may start mid-line)
  logic [OFFS_W-1:0]         r_cnt;    // beats accepted so far
  logic                      r_done;
  logic                      w_accept;
  logic                      w_beat;
  logic [OFFS_W-1:0]         w_start;

`ifdef RF_REFILL_CRITICAL_WORD_FIRST_EN
  assign w_start = refill_req_addr[WOFF_LSB +: OFFS_W];
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    refill_req_ready = 1'b0;
    mem_req_valid    = 1'b0;
    mem_rsp_ready    = 1'b0;
    w_accept         = 1'b0;
    w_beat           = 1'b0;
    case (r_state)
      IDLE: begin
        refill_req_ready = 1'b1;
        if (refill_req_valid) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = BEAT;
      end
      BEAT: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) begin
          w_beat = 1'b1;
          if (r_cnt == LAST_BEAT) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_line <= '0;
      r_offs <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      // DONE coincides with the last write strobe, so the pulse is registered
      // to land one cycle later, once the line is fully in the register file.
      r_done <= (r_state == DONE);
      if (w_accept) begin
        r_addr <= refill_req_addr;
        r_line <= refill_req_line;
        r_offs <= w_start;
        r_cnt  <= '0;
      end else if (w_beat) begin
        r_offs <= r_offs + OFFS_W'(1);
        r_cnt  <= r_cnt + OFFS_W'(1);
      end
    end
  end

  assign mem_req_addr = r_addr & ALIGN_MASK;
  assign refill_done  = r_done;

  rf_refill_wr_stage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_stage (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_beat),
    .i_addr ({r_line, r_offs}),
    .i_data (mem_rsp_data),
    .o_we   (WriteEnable),
    .o_addr (WriteAddr),
    .o_data (WriteData)
  );

endmodule

// File: tb/tb_rf_refill_writer.sv
// Directed bench for rf_refill_writer with a write scoreboard.
// Expectations follow RF_REFILL_CRITICAL_WORD_FIRST_EN when it is defined.
module tb_rf_refill_writer;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int MAW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           refill_req_valid;
  logic           refill_req_ready;
  logic [MAW-1:0] refill_req_addr;
  logic [2:0]     refill_req_line;
  logic           mem_req_valid;
  logic           mem_req_ready;
  logic [MAW-1:0] mem_req_addr;
  logic           mem_rsp_valid;
  logic           mem_rsp_ready;
  logic [DW-1:0]  mem_rsp_data;
  logic           WriteEnable;
  logic [AW-1:0]  WriteAddr;
  logic [DW-1:0]  WriteData;
  logic           refill_done;

  always #5 clk = ~clk;

  rf_refill_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .MEM_ADDR_WIDTH(MAW)
  ) dut (
    .clk(clk), .rst(rst),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_addr(refill_req_addr), .refill_req_line(refill_req_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .refill_done(refill_done)
  );

  int   checks = 0;
  int   failures = 0;
  int   n_we = 0;
  int   n_done = 0;
  logic last_we = 1'b0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;

  // Monitor: every write must match the head of the scoreboard, and every
  // done pulse must directly follow a write strobe.
  always @(negedge clk) begin
    if (WriteEnable === 1'b1) begin
      n_we++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%0d data=%h expected none", WriteAddr, WriteData);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert ({WriteAddr, WriteData} === exp_w) else begin
          failures++;
          $error("FAIL write observed addr=%0d data=%h expected addr=%0d data=%h",
                 WriteAddr, WriteData, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
    if (refill_done === 1'b1) begin
      n_done++;
      checks++;
      assert (last_we === 1'b1) else begin
        failures++;
        $error("FAIL done_after_write observed prev_we=%b expected 1", last_we);
      end
    end
    last_we = WriteEnable;
  end

  function automatic logic [MAW-1:0] exp_maddr(input logic [MAW-1:0] a);
`ifdef RF_REFILL_CRITICAL_WORD_FIRST_EN
    return a & ~32'h3;
`else
    return a & ~32'hF;
`endif
  endfunction

  function automatic int start_offs(input logic [MAW-1:0] a);
`ifdef RF_REFILL_CRITICAL_WORD_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [MAW-1:0] a, input int line, input int base, input int n);
    int offs;
    for (int i = 0; i < n; i++) begin
      offs = (start_offs(a) + i) % LW;
      exp_q.push_back({AW'(line * LW + offs), DW'(base + i)});
    end
  endtask

  task automatic issue_cmd(input logic [MAW-1:0] a, input int line);
    int k;
    refill_req_valid = 1'b1;
    refill_req_addr  = a;
    refill_req_line  = 3'(line);
    k = 0;
    while (refill_req_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    chk("cmd_ready_timeout", 64'(k < 50), 64'd1);
    step();
    refill_req_valid = 1'b0;
  endtask

  task automatic serve(input logic [MAW-1:0] maddr, input int base, input int stall,
                       input bit gaps, input int nbeats);
    int k;
    k = 0;
    while (mem_req_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("mreq_valid", 64'(mem_req_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      mem_req_ready = 1'b0;
      chk("mreq_valid_stall", 64'(mem_req_valid), 64'd1);
      chk("mreq_addr_stall", 64'(mem_req_addr), 64'(maddr));
      step();
    end
    mem_req_ready = 1'b1;
    chk("mreq_addr", 64'(mem_req_addr), 64'(maddr));
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = DW'(base + i);
      chk("rsp_ready", 64'(mem_rsp_ready), 64'd1);
      step();
      mem_rsp_valid = 1'b0;
      if (gaps) begin
        step();
        chk("gap_no_we", 64'(WriteEnable), 64'd0);
      end
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 20) begin
      step();
      k++;
    end
    chk("done_count", 64'(n_done), 64'(target));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int we0;
    logic [MAW-1:0] a;

    rst = 1'b1;
    refill_req_valid = 1'b0;
    refill_req_addr  = '0;
    refill_req_line  = '0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_data     = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_we",        64'(WriteEnable),      64'd0);
    chk("rst_waddr",     64'(WriteAddr),        64'd0);
    chk("rst_wdata",     64'(WriteData),        64'd0);
    chk("rst_mreq",      64'(mem_req_valid),    64'd0);
    chk("rst_mrsp",      64'(mem_rsp_ready),    64'd0);
    chk("rst_done",      64'(refill_done),      64'd0);
    chk("rst_ready",     64'(refill_req_ready), 64'd1);

    // Basic fill
    a = 32'h1000_0008; we0 = n_we;
    push_exp(a, 3, 'hA0, 4);
    issue_cmd(a, 3);
    serve(exp_maddr(a), 'hA0, 0, 1'b0, 4);
    wait_done(1);
    chk("basic_we_count", 64'(n_we - we0), 64'd4);

    // Request stall and response gaps
    a = 32'h3000_0017; we0 = n_we;
    push_exp(a, 0, 'hC0, 4);
    issue_cmd(a, 0);
    serve(exp_maddr(a), 'hC0, 5, 1'b1, 4);
    wait_done(2);
    chk("stall_we_count", 64'(n_we - we0), 64'd4);

    // Word offset 2 in line 1 (wraps only when critical-word-first is on)
    a = 32'h2000_0048;
    push_exp(a, 1, 'hD0, 4);
    issue_cmd(a, 1);
    serve(exp_maddr(a), 'hD0, 0, 1'b0, 4);
    wait_done(3);

    // Reset after the second beat
    a = 32'h0000_0104;
    push_exp(a, 2, 'hB0, 2);
    issue_cmd(a, 2);
    serve(exp_maddr(a), 'hB0, 0, 1'b0, 2);
    chk("we_before_rst", 64'(WriteEnable), 64'd1);
    rst = 1'b1;
    step();
    chk("midrst_we",    64'(WriteEnable),      64'd0);
    chk("midrst_ready", 64'(refill_req_ready), 64'd1);
    chk("midrst_mreq",  64'(mem_req_valid),    64'd0);
    chk("midrst_mrsp",  64'(mem_rsp_ready),    64'd0);
    chk("midrst_done",  64'(refill_done),      64'd0);
    rst = 1'b0;
    repeat (5) step();
    chk("midrst_no_done", 64'(n_done), 64'd3);
    chk("midrst_queue",   64'(exp_q.size()), 64'd0);

    // Back-to-back: second command held valid through DONE
    a = 32'h0000_0200;
    push_exp(a, 0, 'hE0, 4);
    issue_cmd(a, 0);
    serve(exp_maddr(a), 'hE0, 0, 1'b0, 4);
    refill_req_valid = 1'b1;
    refill_req_addr  = 32'h0000_0334;
    refill_req_line  = 3'd3;
    chk("b2b_ready_in_done", 64'(refill_req_ready), 64'd0);
    step();
    chk("b2b_ready_idle", 64'(refill_req_ready), 64'd1);
    chk("b2b_done_pulse", 64'(refill_done),      64'd1);
    push_exp(32'h0000_0334, 3, 'hF0, 4);
    step();
    refill_req_valid = 1'b0;
    chk("b2b_accepted", 64'(refill_req_ready), 64'd0);
    chk("b2b_mreq",     64'(mem_req_valid),    64'd1);
    serve(exp_maddr(32'h0000_0334), 'hF0, 0, 1'b0, 4);
    wait_done(5);

    // Spurious response while idle
    step();
    we0 = n_we;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      chk("spur_rsp_ready", 64'(mem_rsp_ready), 64'd0);
      step();
    end
    mem_rsp_valid = 1'b0;
    step();
    chk("spur_no_we",  64'(n_we - we0), 64'd0);
    chk("spur_no_done", 64'(n_done),    64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
